// File: rtl/ps2_note_tracker.sv
// ps2_note_tracker: PS/2 Set-2 scan-code decoder that turns two piano-layout
// keyboard rows into the 88-bit held-note vector consumed by adio_codec.
// Ports:
//   iCLK, iRST     clock, synchronous active-high reset
//   iSCAN_CODE     received PS/2 byte, qualified by iSCAN_VALID
//   iSCAN_VALID    one-cycle byte strobe
//   oSOUND         bit i set = note i held (0 = A0 .. 87 = C8)
//   oKEY_PRESSED   OR-reduction of oSOUND, registered alongside it
//   oHELD_COUNT    number of held physical keys
//   oOCTAVE        signed octave offset, -3..+3
//   oDROP          one-cycle pulse when a press is dropped
module ps2_note_tracker #(
  parameter int unsigned BASE_KEY = 39,
  parameter int unsigned MAX_HELD = 10,
  parameter int unsigned TIMEOUT  = 50000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [7:0]  iSCAN_CODE,
  input  logic        iSCAN_VALID,
  output logic [87:0] oSOUND,
  output logic        oKEY_PRESSED,
  output logic [3:0]  oHELD_COUNT,
  output logic [2:0]  oOCTAVE,
  output logic        oDROP
);

  localparam int unsigned NUM_SLOTS = 26;
  localparam int unsigned NOTES     = 88;
  localparam int unsigned TW        = $clog2(TIMEOUT + 1);

  localparam logic [7:0] CODE_BRK  = 8'hF0;
  localparam logic [7:0] CODE_EXT  = 8'hE0;
  localparam logic [7:0] CODE_DOWN = 8'h4E;
  localparam logic [7:0] CODE_UP   = 8'h55;
  localparam logic [7:0] CODE_ESC  = 8'h76;

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BRK} state_t;

  state_t          state, state_n;
  logic [TW-1:0]   tmo_cnt;
  logic            make_ev, brk_ev;

  logic [NUM_SLOTS-1:0] valid_tab;
  logic [6:0]           note_tab [NUM_SLOTS];

  logic                 hit;
  logic [4:0]           slot;
  logic [4:0]           offset;
  logic signed [8:0]    oct_s;
  logic signed [8:0]    note_calc;
  logic                 note_bad;
  logic [NOTES-1:0]     sound_c;

  // Scan code -> {hit, slot}; slots 0-12 lower row, 13-25 upper row
  function automatic logic [5:0] slot_of(input logic [7:0] c);
    case (c)
      8'h1A: slot_of = {1'b1, 5'd0};
      8'h1B: slot_of = {1'b1, 5'd1};
      8'h22: slot_of = {1'b1, 5'd2};
      8'h23: slot_of = {1'b1, 5'd3};
      8'h21: slot_of = {1'b1, 5'd4};
      8'h2A: slot_of = {1'b1, 5'd5};
      8'h34: slot_of = {1'b1, 5'd6};
      8'h32: slot_of = {1'b1, 5'd7};
      8'h33: slot_of = {1'b1, 5'd8};
      8'h31: slot_of = {1'b1, 5'd9};
      8'h3B: slot_of = {1'b1, 5'd10};
      8'h3A: slot_of = {1'b1, 5'd11};
      8'h41: slot_of = {1'b1, 5'd12};
      8'h15: slot_of = {1'b1, 5'd13};
      8'h1E: slot_of = {1'b1, 5'd14};
      8'h1D: slot_of = {1'b1, 5'd15};
      8'h26: slot_of = {1'b1, 5'd16};
      8'h24: slot_of = {1'b1, 5'd17};
      8'h2D: slot_of = {1'b1, 5'd18};
      8'h2E: slot_of = {1'b1, 5'd19};
      8'h2C: slot_of = {1'b1, 5'd20};
      8'h36: slot_of = {1'b1, 5'd21};
      8'h35: slot_of = {1'b1, 5'd22};
      8'h3D: slot_of = {1'b1, 5'd23};
      8'h3C: slot_of = {1'b1, 5'd24};
      8'h43: slot_of = {1'b1, 5'd25};
      default: slot_of = 6'd0;
    endcase
  endfunction

  // Key lookup and note arithmetic for the incoming byte
  always_comb begin
    {hit, slot} = slot_of(iSCAN_CODE);
    // upper row starts one octave above the lower row's first key
    offset    = (slot < 5'd13) ? slot : 5'(slot - 5'd1);
    oct_s     = {{6{oOCTAVE[2]}}, oOCTAVE};
    note_calc = $signed(9'(BASE_KEY)) + $signed({4'd0, offset}) + oct_s * 9'sd12;
    note_bad  = (note_calc < 9'sd0) || (note_calc > 9'sd87);
  end

  // FSM state register
  always_ff @(posedge iCLK) begin
    if (iRST) state <= S_IDLE;
    else      state <= state_n;
  end

  // FSM next state and event strobes
  always_comb begin
    state_n = state;
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    if (iSCAN_VALID) begin
      case (state)
        S_IDLE: begin
          if (iSCAN_CODE == CODE_BRK)      state_n = S_BREAK;
          else if (iSCAN_CODE == CODE_EXT) state_n = S_EXT;
          else                             make_ev = 1'b1;
        end
        S_BREAK: begin
          if (iSCAN_CODE != CODE_BRK) begin
            brk_ev  = 1'b1;
            state_n = S_IDLE;
          end
        end
        S_EXT:     state_n = (iSCAN_CODE == CODE_BRK) ? S_EXT_BRK : S_IDLE;
        S_EXT_BRK: state_n = S_IDLE;
        default:   state_n = S_IDLE;
      endcase
    end else if (state != S_IDLE && tmo_cnt == TW'(TIMEOUT - 1)) begin
      state_n = S_IDLE;
    end
  end

  // Prefix timeout: counts idle cycles while a prefix is pending
  always_ff @(posedge iCLK) begin
    if (iRST || iSCAN_VALID || state == S_IDLE) tmo_cnt <= '0;
    else                                        tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Held-key table, count, octave and drop pulse
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      valid_tab   <= '0;
      oHELD_COUNT <= '0;
      oOCTAVE     <= '0;
      oDROP       <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) note_tab[i] <= '0;
    end else begin
      oDROP <= 1'b0;
      if (make_ev) begin
        if (iSCAN_CODE == CODE_UP) begin
          if (oOCTAVE != 3'd3) oOCTAVE <= oOCTAVE + 3'd1;
        end else if (iSCAN_CODE == CODE_DOWN) begin
          if (oOCTAVE != 3'b101) oOCTAVE <= oOCTAVE - 3'd1;
        end else if (iSCAN_CODE == CODE_ESC) begin
          valid_tab   <= '0;
          oHELD_COUNT <= '0;
        end else if (hit && !valid_tab[slot]) begin
          // typematic repeats of a held slot fall through silently
          if (note_bad || oHELD_COUNT == 4'(MAX_HELD)) begin
            oDROP <= 1'b1;
          end else begin
            valid_tab[slot] <= 1'b1;
            note_tab[slot]  <= note_calc[6:0];
            oHELD_COUNT     <= oHELD_COUNT + 4'd1;
          end
        end
      end
      if (brk_ev && hit && valid_tab[slot]) begin
        valid_tab[slot] <= 1'b0;
        oHELD_COUNT     <= oHELD_COUNT - 4'd1;
      end
    end
  end

  // Note vector from the table: shared notes stay set until all owners release
  always_comb begin
    sound_c = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (valid_tab[i]) sound_c[note_tab[i]] = 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oSOUND       <= '0;
      oKEY_PRESSED <= 1'b0;
    end else begin
      oSOUND       <= sound_c;
      oKEY_PRESSED <= |sound_c;
    end
  end

endmodule

// File: tb/tb_ps2_note_tracker.sv
// Testbench for ps2_note_tracker: directed byte table plus hand sequences
// for capacity, prefix timeout, back-to-back bytes and mid-stream reset.
module tb_ps2_note_tracker;

  localparam int unsigned TMO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  code;
  logic        vld;
  logic [87:0] sound;
  logic        kp;
  logic [3:0]  cnt;
  logic [2:0]  oct;
  logic        drop;

  int total = 0;
  int bad   = 0;

  ps2_note_tracker #(.BASE_KEY(39), .MAX_HELD(10), .TIMEOUT(TMO)) dut (
    .iCLK(clk), .iRST(rst), .iSCAN_CODE(code), .iSCAN_VALID(vld),
    .oSOUND(sound), .oKEY_PRESSED(kp), .oHELD_COUNT(cnt),
    .oOCTAVE(oct), .oDROP(drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  code;
    logic [3:0]  cnt;
    logic [2:0]  oct;
    logic        drop;
    logic [87:0] snd;
  } vec_t;

  vec_t vecs [$];

  function automatic logic [87:0] nb(input int n);
    logic [87:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One byte strobe; returns at the negedge after the accepting edge
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    code = b;
    vld  = 1'b1;
    @(negedge clk);
    vld  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic add(input logic [7:0] c, input logic [3:0] n, input logic [2:0] o,
                     input logic d, input logic [87:0] s);
    vec_t v;
    v.code = c; v.cnt = n; v.oct = o; v.drop = d; v.snd = s;
    vecs.push_back(v);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [87:0] exp_snd;

  initial begin
    rst = 1'b1; code = '0; vld = 1'b0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_sound", sound, '0);
    chk("reset_kp", 88'(kp), 88'(0));
    chk("reset_cnt", 88'(cnt), 88'(0));
    chk("reset_oct", 88'(oct), 88'(0));
    chk("reset_drop", 88'(drop), 88'(0));

    // code, held count, octave, drop, sound (one cycle after count)
    add(8'h1A, 4'd1, 3'd0, 1'b0, nb(39));   // Z = C4
    add(8'h1A, 4'd1, 3'd0, 1'b0, nb(39));   // typematic repeat
    add(8'h1A, 4'd1, 3'd0, 1'b0, nb(39));
    add(8'hF0, 4'd1, 3'd0, 1'b0, nb(39));
    add(8'h1A, 4'd0, 3'd0, 1'b0, '0);
    add(8'h55, 4'd0, 3'd1, 1'b0, '0);
    add(8'h1A, 4'd1, 3'd1, 1'b0, nb(51));   // Z at +1 octave
    add(8'h4E, 4'd1, 3'd0, 1'b0, nb(51));   // octave change keeps held note
    add(8'h15, 4'd2, 3'd0, 1'b0, nb(51));   // Q at octave 0 = same note
    add(8'hF0, 4'd2, 3'd0, 1'b0, nb(51));
    add(8'h1A, 4'd1, 3'd0, 1'b0, nb(51));   // shared note stays
    add(8'hF0, 4'd1, 3'd0, 1'b0, nb(51));
    add(8'h15, 4'd0, 3'd0, 1'b0, '0);
    add(8'h55, 4'd0, 3'd1, 1'b0, '0);
    add(8'h55, 4'd0, 3'd2, 1'b0, '0);
    add(8'h55, 4'd0, 3'd3, 1'b0, '0);
    add(8'h55, 4'd0, 3'd3, 1'b0, '0);       // saturate high
    add(8'h43, 4'd0, 3'd3, 1'b1, '0);       // note 99 dropped
    add(8'h15, 4'd1, 3'd3, 1'b0, nb(87));   // note 87 = C8
    add(8'h4E, 4'd1, 3'd2, 1'b0, nb(87));
    add(8'hF0, 4'd1, 3'd2, 1'b0, nb(87));
    add(8'h4E, 4'd1, 3'd2, 1'b0, nb(87));   // control break ignored
    add(8'h76, 4'd0, 3'd2, 1'b0, '0);       // Esc
    add(8'h4E, 4'd0, 3'd1, 1'b0, '0);
    add(8'h4E, 4'd0, 3'd0, 1'b0, '0);
    add(8'h4E, 4'd0, 3'd7, 1'b0, '0);
    add(8'h4E, 4'd0, 3'd6, 1'b0, '0);
    add(8'h4E, 4'd0, 3'd5, 1'b0, '0);
    add(8'h4E, 4'd0, 3'd5, 1'b0, '0);       // saturate low
    add(8'h1A, 4'd1, 3'd5, 1'b0, nb(3));    // 39 - 36
    add(8'h55, 4'd1, 3'd6, 1'b0, nb(3));
    add(8'h55, 4'd1, 3'd7, 1'b0, nb(3));
    add(8'h55, 4'd1, 3'd0, 1'b0, nb(3));
    add(8'h76, 4'd0, 3'd0, 1'b0, '0);
    add(8'hE0, 4'd0, 3'd0, 1'b0, '0);
    add(8'h1A, 4'd0, 3'd0, 1'b0, '0);       // extended: no event
    add(8'hE0, 4'd0, 3'd0, 1'b0, '0);
    add(8'hF0, 4'd0, 3'd0, 1'b0, '0);
    add(8'h1A, 4'd0, 3'd0, 1'b0, '0);       // extended break: no event
    add(8'hAA, 4'd0, 3'd0, 1'b0, '0);       // unmapped ignored
    add(8'h41, 4'd1, 3'd0, 1'b0, nb(51));   // ',' = +12

    foreach (vecs[i]) begin
      send(vecs[i].code);
      chk($sformatf("v%0d_cnt", i), 88'(cnt), 88'(vecs[i].cnt));
      chk($sformatf("v%0d_oct", i), 88'(oct), 88'(vecs[i].oct));
      chk($sformatf("v%0d_drop", i), 88'(drop), 88'(vecs[i].drop));
      @(negedge clk);
      chk($sformatf("v%0d_snd", i), sound, vecs[i].snd);
      chk($sformatf("v%0d_kp", i), 88'(kp), 88'(vecs[i].snd != '0));
    end

    // Capacity: ten distinct keys, then an eleventh is dropped
    send(8'h76);
    begin
      logic [7:0] keys [11];
      keys = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32, 8'h33, 8'h31, 8'h3B};
      exp_snd = '0;
      for (int k = 0; k < 10; k++) begin
        send(keys[k]);
        exp_snd[39 + k] = 1'b1;
      end
      chk("cap_cnt10", 88'(cnt), 88'(10));
      send(keys[10]);
      chk("cap_drop", 88'(drop), 88'(1));
      chk("cap_cnt_still10", 88'(cnt), 88'(10));
      @(negedge clk);
      chk("cap_drop_pulse_ends", 88'(drop), 88'(0));
      chk("cap_sound", sound, exp_snd);
    end
    send(8'h76);
    @(negedge clk);
    chk("esc_cnt", 88'(cnt), 88'(0));
    chk("esc_sound", sound, '0);

    // Pending break outlives a short gap
    send(8'h1A);
    send(8'hF0);
    idle(10);
    send(8'h1A);
    chk("short_gap_break_cnt", 88'(cnt), 88'(0));

    // Prefix expires after the timeout; following byte is a make
    send(8'hF0);
    idle(TMO + 1);
    send(8'h1A);
    @(negedge clk);
    chk("timeout_make_cnt", 88'(cnt), 88'(1));
    chk("timeout_make_snd", sound, nb(39));

    // Back-to-back bytes on consecutive cycles: F0 1A, 1B
    @(negedge clk);
    code = 8'hF0; vld = 1'b1;
    @(negedge clk);
    code = 8'h1A;
    @(negedge clk);
    code = 8'h1B;
    @(negedge clk);
    vld = 1'b0;
    chk("b2b_cnt", 88'(cnt), 88'(1));
    @(negedge clk);
    chk("b2b_snd", sound, nb(40));

    // Reset mid-sequence after F0
    send(8'hF0);
    do_reset();
    chk("midrst_sound", sound, '0);
    chk("midrst_kp", 88'(kp), 88'(0));
    chk("midrst_cnt", 88'(cnt), 88'(0));
    chk("midrst_oct", 88'(oct), 88'(0));
    send(8'h1B);
    @(negedge clk);
    chk("midrst_make_cnt", 88'(cnt), 88'(1));
    chk("midrst_make_snd", sound, nb(40));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
